// File: rtl/nfc_pkg.sv
// nfc_pkg: shared definitions for the ISO14443A cascade detector.
//   det_state_e  - detector sequence states
//   xact_state_e - single-transaction engine states
//   register addresses, command bytes, SEL codes, cascade tag, error codes
package nfc_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StReqa,
        StAnticoll,
        StReadUid,
        StChkBcc,
        StSelect,
        StChkSak,
        StDone,
        StError
    } det_state_e;

    typedef enum logic [1:0] {
        XIdle,
        XIssue,
        XWait
    } xact_state_e;

    localparam logic [5:0] CmdReg  = 6'h01;
    localparam logic [5:0] SelReg  = 6'h02;
    localparam logic [5:0] FifoReg = 6'h09;

    localparam logic [7:0] CmdReqa    = 8'h26;
    localparam logic [7:0] CmdSelect  = 8'h50;
    localparam logic [7:0] CascadeTag = 8'h88;

    localparam logic [7:0] ErrNone    = 8'h00;
    localparam logic [7:0] ErrAtqa    = 8'h01;
    localparam logic [7:0] ErrBcc     = 8'h02;
    localparam logic [7:0] ErrSak     = 8'h03;
    localparam logic [7:0] ErrCascade = 8'h04;
    localparam logic [7:0] ErrTimeout = 8'h05;

    // Anticollision SEL code for cascade level 0/1/2.
    function automatic logic [7:0] sel_code(input logic [1:0] level);
        logic [7:0] code;
        case (level)
            2'd0:    code = 8'h93;
            2'd1:    code = 8'h95;
            default: code = 8'h97;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/nfc_cmd_xact.sv
// nfc_cmd_xact: issues one front-end command and waits for its completion.
//   clk, rst              - clock, synchronous active-high reset
//   start_i               - launch a transaction (only honoured when idle)
//   write_i/addr_i/wdata_i- command fields, latched on start_i
//   xact_ok_o             - one-cycle pulse, done seen; rdata_o valid from then on
//   xact_timeout_o        - one-cycle pulse, no done within TIMEOUT_CYCLES of accept
//   rdata_o               - response byte captured on the done cycle
//   cmd_*                 - front-end valid/ready/done command bus
module nfc_cmd_xact
    import nfc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       write_i,
    input  logic [5:0] addr_i,
    input  logic [7:0] wdata_i,
    output logic       xact_ok_o,
    output logic       xact_timeout_o,
    output logic [7:0] rdata_o,
    output logic       cmd_valid_o,
    output logic       cmd_write_o,
    output logic [5:0] cmd_addr_o,
    output logic [7:0] cmd_wdata_o,
    input  logic       cmd_ready_i,
    input  logic       cmd_done_i,
    input  logic [7:0] cmd_rdata_i
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    xact_state_e   state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic          write_q, write_d;
    logic [5:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          ok_q, ok_d;
    logic          to_q, to_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= XIdle;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ok_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ok_q    <= ok_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ok_d    = 1'b0;
        to_d    = 1'b0;
        case (state_q)
            XIdle: begin
                if (start_i) begin
                    write_d = write_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    state_d = XIssue;
                end
            end
            XIssue: begin
                // The accept cycle counts as the first elapsed cycle.
                if (cmd_ready_i) begin
                    cnt_d   = CntW'(1);
                    state_d = XWait;
                end
            end
            XWait: begin
                // done is checked first so it wins over a coincident timeout.
                if (cmd_done_i) begin
                    rdata_d = cmd_rdata_i;
                    ok_d    = 1'b1;
                    state_d = XIdle;
                end else if (cnt_q >= CntW'(TIMEOUT_CYCLES)) begin
                    to_d    = 1'b1;
                    state_d = XIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = XIdle;
        endcase
    end

    assign cmd_valid_o    = (state_q == XIssue);
    assign cmd_write_o    = write_q;
    assign cmd_addr_o     = addr_q;
    assign cmd_wdata_o    = wdata_q;
    assign xact_ok_o      = ok_q;
    assign xact_timeout_o = to_q;
    assign rdata_o        = rdata_q;

endmodule

// File: rtl/nfc_cascade_detector.sv
// nfc_cascade_detector: ISO14443A REQA/ANTICOLL/SELECT sequencer with cascade levels,
// per-transaction timeout and full-sequence retry.
//   clk, rst          - clock, synchronous active-high reset
//   nfc_irq           - card-present level; rising edge in idle starts a sequence
//   nfc_cmd_*         - front-end command bus (see nfc_cmd_xact)
//   card_detected     - high while a sequence runs (through DONE/ERROR cycle)
//   card_uid/uid_len  - assembled UID (first byte in [7:0]) and its length
//   card_sak          - final SAK
//   card_ready/start_auth - coincident one-cycle success pulses
//   detection_error   - one-cycle terminal failure pulse; error_code holds last error
module nfc_cascade_detector
    import nfc_pkg::*;
#(
    parameter int unsigned MAX_CASCADE    = 3,
    parameter int unsigned MAX_RETRIES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned UID_W         = 8 * (3 * MAX_CASCADE + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             nfc_irq,
    output logic             nfc_cmd_valid,
    input  logic             nfc_cmd_ready,
    output logic             nfc_cmd_write,
    output logic [5:0]       nfc_cmd_addr,
    output logic [7:0]       nfc_cmd_wdata,
    input  logic [7:0]       nfc_cmd_rdata,
    input  logic             nfc_cmd_done,
    output logic             card_detected,
    output logic [UID_W-1:0] card_uid,
    output logic [3:0]       uid_len,
    output logic [7:0]       card_sak,
    output logic             card_ready,
    output logic             start_auth,
    output logic             detection_error,
    output logic [7:0]       error_code
);

    det_state_e       state_q, state_d;
    logic             irq_q;
    logic             issued_q, issued_d;
    logic [1:0]       level_q, level_d;
    logic [3:0]       retry_q, retry_d;
    logic [2:0]       idx_q, idx_d;
    logic [4:0][7:0]  bytes_q, bytes_d;
    logic             tag_q, tag_d;
    logic [7:0]       sak_q, sak_d;
    logic [UID_W-1:0] uid_q, uid_d;
    logic [3:0]       uid_cnt_q, uid_cnt_d;
    logic [3:0]       uid_len_q, uid_len_d;
    logic [7:0]       card_sak_q, card_sak_d;
    logic [7:0]       err_q, err_d;

    logic       xs_start, xs_write;
    logic [5:0] xs_addr;
    logic [7:0] xs_wdata;
    logic       xact_ok, xact_timeout;
    logic [7:0] xact_rdata;

    logic       fail_fatal, fail_retry;
    logic [7:0] fail_code;
    logic [7:0] bcc_calc;

    nfc_cmd_xact #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_xact (
        .clk           (clk),
        .rst           (rst),
        .start_i       (xs_start),
        .write_i       (xs_write),
        .addr_i        (xs_addr),
        .wdata_i       (xs_wdata),
        .xact_ok_o     (xact_ok),
        .xact_timeout_o(xact_timeout),
        .rdata_o       (xact_rdata),
        .cmd_valid_o   (nfc_cmd_valid),
        .cmd_write_o   (nfc_cmd_write),
        .cmd_addr_o    (nfc_cmd_addr),
        .cmd_wdata_o   (nfc_cmd_wdata),
        .cmd_ready_i   (nfc_cmd_ready),
        .cmd_done_i    (nfc_cmd_done),
        .cmd_rdata_i   (nfc_cmd_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            irq_q      <= 1'b0;
            issued_q   <= 1'b0;
            level_q    <= '0;
            retry_q    <= '0;
            idx_q      <= '0;
            bytes_q    <= '0;
            tag_q      <= 1'b0;
            sak_q      <= '0;
            uid_q      <= '0;
            uid_cnt_q  <= '0;
            uid_len_q  <= '0;
            card_sak_q <= '0;
            err_q      <= ErrNone;
        end else begin
            state_q    <= state_d;
            irq_q      <= nfc_irq;
            issued_q   <= issued_d;
            level_q    <= level_d;
            retry_q    <= retry_d;
            idx_q      <= idx_d;
            bytes_q    <= bytes_d;
            tag_q      <= tag_d;
            sak_q      <= sak_d;
            uid_q      <= uid_d;
            uid_cnt_q  <= uid_cnt_d;
            uid_len_q  <= uid_len_d;
            card_sak_q <= card_sak_d;
            err_q      <= err_d;
        end
    end

    assign bcc_calc = bytes_q[0] ^ bytes_q[1] ^ bytes_q[2] ^ bytes_q[3];

    always_comb begin
        state_d    = state_q;
        issued_d   = issued_q;
        level_d    = level_q;
        retry_d    = retry_q;
        idx_d      = idx_q;
        bytes_d    = bytes_q;
        tag_d      = tag_q;
        sak_d      = sak_q;
        uid_d      = uid_q;
        uid_cnt_d  = uid_cnt_q;
        uid_len_d  = uid_len_q;
        card_sak_d = card_sak_q;
        err_d      = err_q;
        xs_start   = 1'b0;
        xs_write   = 1'b1;
        xs_addr    = CmdReg;
        xs_wdata   = 8'h00;
        fail_fatal = 1'b0;
        fail_retry = 1'b0;
        fail_code  = ErrNone;

        case (state_q)
            StIdle: begin
                if (nfc_irq && !irq_q) begin
                    uid_d      = '0;
                    uid_cnt_d  = '0;
                    uid_len_d  = '0;
                    card_sak_d = '0;
                    retry_d    = '0;
                    level_d    = '0;
                    tag_d      = 1'b0;
                    state_d    = StReqa;
                end
            end
            StReqa: begin
                xs_wdata = CmdReqa;
                if (xact_ok) begin
                    if (xact_rdata == 8'h00 || xact_rdata == 8'hFF) begin
                        fail_fatal = 1'b1;
                        fail_code  = ErrAtqa;
                    end else begin
                        state_d = StAnticoll;
                    end
                end
            end
            StAnticoll: begin
                xs_addr  = SelReg;
                xs_wdata = sel_code(level_q);
                if (xact_ok) begin
                    idx_d   = '0;
                    state_d = StReadUid;
                end
            end
            StReadUid: begin
                xs_write = 1'b0;
                xs_addr  = FifoReg;
                if (xact_ok) begin
                    bytes_d[idx_q] = xact_rdata;
                    if (idx_q == 3'd4) begin
                        state_d = StChkBcc;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            StChkBcc: begin
                if (bcc_calc != bytes_q[4]) begin
                    fail_retry = 1'b1;
                    fail_code  = ErrBcc;
                end else if (bytes_q[0] == CascadeTag) begin
                    // Cascade tag is not part of the UID; only b1..b3 are kept.
                    tag_d = 1'b1;
                    for (int i = 0; i < 3; i++) begin
                        uid_d[8*(int'(uid_cnt_q)+i) +: 8] = bytes_q[i+1];
                    end
                    uid_cnt_d = uid_cnt_q + 4'd3;
                    state_d   = StSelect;
                end else begin
                    tag_d = 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        uid_d[8*(int'(uid_cnt_q)+i) +: 8] = bytes_q[i];
                    end
                    uid_cnt_d = uid_cnt_q + 4'd4;
                    state_d   = StSelect;
                end
            end
            StSelect: begin
                xs_wdata = CmdSelect | {6'b0, level_q};
                if (xact_ok) begin
                    sak_d   = xact_rdata;
                    state_d = StChkSak;
                end
            end
            StChkSak: begin
                // SAK bit2 means "UID not complete" and must agree with the tag.
                if (sak_q[2] != tag_q) begin
                    fail_fatal = 1'b1;
                    fail_code  = ErrSak;
                end else if (sak_q[2]) begin
                    if (32'(level_q) + 32'd1 == MAX_CASCADE) begin
                        fail_fatal = 1'b1;
                        fail_code  = ErrCascade;
                    end else begin
                        level_d = level_q + 2'd1;
                        state_d = StAnticoll;
                    end
                end else begin
                    uid_len_d  = uid_cnt_q;
                    card_sak_d = sak_q;
                    state_d    = StDone;
                end
            end
            StDone:  state_d = StIdle;
            StError: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Each transaction state launches exactly one command, then waits for its outcome.
        if (state_q inside {StReqa, StAnticoll, StReadUid, StSelect}) begin
            xs_start = !issued_q;
            issued_d = !(xact_ok || xact_timeout);
            if (xact_timeout) begin
                fail_retry = 1'b1;
                fail_code  = ErrTimeout;
            end
        end

        if (fail_retry) begin
            err_d = fail_code;
            if (32'(retry_q) < MAX_RETRIES) begin
                retry_d   = retry_q + 4'd1;
                uid_d     = '0;
                uid_cnt_d = '0;
                level_d   = '0;
                state_d   = StReqa;
            end else begin
                state_d = StError;
            end
        end

        if (fail_fatal) begin
            err_d   = fail_code;
            state_d = StError;
        end
    end

    assign card_detected   = (state_q != StIdle);
    assign card_uid        = uid_q;
    assign uid_len         = uid_len_q;
    assign card_sak        = card_sak_q;
    assign card_ready      = (state_q == StDone);
    assign start_auth      = (state_q == StDone);
    assign detection_error = (state_q == StError);
    assign error_code      = err_q;

endmodule

// File: tb/tb_nfc_cascade_detector.sv
// Directed bench for nfc_cascade_detector with a scripted MFRC522 front-end mock.
module tb_nfc_cascade_detector;

    logic        clk;
    logic        rst;
    logic        nfc_irq;
    logic        nfc_cmd_valid;
    logic        nfc_cmd_ready;
    logic        nfc_cmd_write;
    logic [5:0]  nfc_cmd_addr;
    logic [7:0]  nfc_cmd_wdata;
    logic [7:0]  nfc_cmd_rdata;
    logic        nfc_cmd_done;
    logic        card_detected;
    logic [79:0] card_uid;
    logic [3:0]  uid_len;
    logic [7:0]  card_sak;
    logic        card_ready;
    logic        start_auth;
    logic        detection_error;
    logic [7:0]  error_code;

    nfc_cascade_detector dut (
        .clk            (clk),
        .rst            (rst),
        .nfc_irq        (nfc_irq),
        .nfc_cmd_valid  (nfc_cmd_valid),
        .nfc_cmd_ready  (nfc_cmd_ready),
        .nfc_cmd_write  (nfc_cmd_write),
        .nfc_cmd_addr   (nfc_cmd_addr),
        .nfc_cmd_wdata  (nfc_cmd_wdata),
        .nfc_cmd_rdata  (nfc_cmd_rdata),
        .nfc_cmd_done   (nfc_cmd_done),
        .card_detected  (card_detected),
        .card_uid       (card_uid),
        .uid_len        (uid_len),
        .card_sak       (card_sak),
        .card_ready     (card_ready),
        .start_auth     (start_auth),
        .detection_error(detection_error),
        .error_code     (error_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor (cumulative; the bench takes deltas).
    int n_ready = 0, n_auth = 0, n_err = 0;
    always @(negedge clk) begin
        if (card_ready)      n_ready <= n_ready + 1;
        if (start_auth)      n_auth  <= n_auth + 1;
        if (detection_error) n_err   <= n_err + 1;
    end

    // Front-end mock state and logs.
    logic [7:0] atqa_v;
    logic       hold_select;
    logic [7:0] fifo_bytes[$];
    logic [7:0] sak_bytes[$];
    logic [7:0] sel_log[$];
    logic [7:0] select_log[$];
    int         reqa_cyc_log[$];
    int         select_cyc_log[$];
    int         n_cmd = 0, n_reqa = 0, n_fifo = 0;

    initial begin : mock
        logic [7:0] resp;
        logic       pend;
        logic       withhold;
        int         lat;
        nfc_cmd_ready = 1'b0;
        nfc_cmd_done  = 1'b0;
        nfc_cmd_rdata = 8'h00;
        pend = 1'b0; withhold = 1'b0; lat = 0; resp = 8'h00;
        forever begin
            @(negedge clk);
            nfc_cmd_done = 1'b0;
            if (rst) begin
                nfc_cmd_ready = 1'b0;
                pend = 1'b0;
            end else if (pend) begin
                if (lat == 0) begin
                    nfc_cmd_done  = 1'b1;
                    nfc_cmd_rdata = resp;
                    pend = 1'b0;
                end else begin
                    lat--;
                end
            end else if (nfc_cmd_ready) begin
                // Accepted on the posedge just gone.
                nfc_cmd_ready = 1'b0;
                pend = !withhold;
                lat  = 1;
            end else if (nfc_cmd_valid) begin
                nfc_cmd_ready = 1'b1;
                n_cmd++;
                withhold = 1'b0;
                resp = 8'h00;
                if (nfc_cmd_write && nfc_cmd_addr == 6'h01 && nfc_cmd_wdata == 8'h26) begin
                    n_reqa++;
                    reqa_cyc_log.push_back(cyc);
                    resp = atqa_v;
                end else if (nfc_cmd_write && nfc_cmd_addr == 6'h02) begin
                    sel_log.push_back(nfc_cmd_wdata);
                end else if (!nfc_cmd_write && nfc_cmd_addr == 6'h09) begin
                    n_fifo++;
                    if (fifo_bytes.size() > 0) resp = fifo_bytes.pop_front();
                end else if (nfc_cmd_write && nfc_cmd_addr == 6'h01 &&
                             nfc_cmd_wdata[7:4] == 4'h5) begin
                    select_log.push_back(nfc_cmd_wdata);
                    select_cyc_log.push_back(cyc);
                    if (sak_bytes.size() > 0) resp = sak_bytes.pop_front();
                    withhold = hold_select;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int   b_cmd, b_reqa, b_fifo, b_ready, b_auth, b_err;
    logic r_ready, r_err, r_det, r_auth;

    task automatic snapshot();
        b_cmd = n_cmd; b_reqa = n_reqa; b_fifo = n_fifo;
        b_ready = n_ready; b_auth = n_auth; b_err = n_err;
        sel_log.delete(); select_log.delete();
        reqa_cyc_log.delete(); select_cyc_log.delete();
    endtask

    task automatic push5(input logic [7:0] a, b, c, d, e);
        fifo_bytes.push_back(a); fifo_bytes.push_back(b); fifo_bytes.push_back(c);
        fifo_bytes.push_back(d); fifo_bytes.push_back(e);
    endtask

    task automatic fire_irq();
        @(posedge clk); #1 nfc_irq = 1'b1;
        repeat (3) @(posedge clk);
        #1 nfc_irq = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        r_ready = 1'b0; r_err = 1'b0; r_det = 1'b0; r_auth = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (card_ready || detection_error) begin
                r_ready = card_ready;
                r_err   = detection_error;
                r_det   = card_detected;
                r_auth  = start_auth;
                break;
            end
        end
    endtask

    task automatic expect_success(input string pfx, input logic [79:0] uid, input logic [3:0] len,
                                  input logic [7:0] sak, input int cmds, input int reqas);
        check({pfx, "_ready"}, r_ready, 1);
        check({pfx, "_auth"}, r_auth, 1);
        check({pfx, "_det_inclusive"}, r_det, 1);
        check({pfx, "_uid"}, card_uid, uid);
        check({pfx, "_len"}, uid_len, len);
        check({pfx, "_sak"}, card_sak, sak);
        repeat (4) @(posedge clk);
        #1;
        check({pfx, "_idle"}, card_detected, 0);
        check({pfx, "_uid_held"}, card_uid, uid);
        check({pfx, "_n_ready"}, n_ready - b_ready, 1);
        check({pfx, "_n_auth"}, n_auth - b_auth, 1);
        check({pfx, "_n_err"}, n_err - b_err, 0);
        check({pfx, "_n_cmd"}, n_cmd - b_cmd, cmds);
        check({pfx, "_n_reqa"}, n_reqa - b_reqa, reqas);
    endtask

    task automatic expect_failure(input string pfx, input logic [7:0] code, input int cmds,
                                  input int reqas);
        check({pfx, "_err"}, r_err, 1);
        check({pfx, "_det_inclusive"}, r_det, 1);
        check({pfx, "_code"}, error_code, code);
        check({pfx, "_len"}, uid_len, 0);
        repeat (4) @(posedge clk);
        #1;
        check({pfx, "_idle"}, card_detected, 0);
        check({pfx, "_code_held"}, error_code, code);
        check({pfx, "_n_err"}, n_err - b_err, 1);
        check({pfx, "_n_ready"}, n_ready - b_ready, 0);
        check({pfx, "_n_cmd"}, n_cmd - b_cmd, cmds);
        check({pfx, "_n_reqa"}, n_reqa - b_reqa, reqas);
    endtask

    initial begin : main
        rst = 1'b1; nfc_irq = 1'b0; atqa_v = 8'h04; hold_select = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", nfc_cmd_valid, 0);
        check("rst_detected", card_detected, 0);
        check("rst_uid", card_uid, 0);
        check("rst_len", uid_len, 0);
        check("rst_sak", card_sak, 0);
        check("rst_ready", card_ready, 0);
        check("rst_auth", start_auth, 0);
        check("rst_deterr", detection_error, 0);
        check("rst_code", error_code, 8'h00);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // 4-byte card; a second IRQ edge mid-sequence must not restart it.
        snapshot();
        push5(8'h78, 8'h56, 8'h34, 8'h12, 8'h08);
        sak_bytes.push_back(8'h08);
        fire_irq();
        repeat (8) @(posedge clk);
        #1 nfc_irq = 1'b1;
        repeat (3) @(posedge clk);
        #1 nfc_irq = 1'b0;
        wait_end(2000);
        expect_success("card4", 80'h12345678, 4'd4, 8'h08, 8, 1);

        // 7-byte card over two cascade levels.
        snapshot();
        atqa_v = 8'h44;
        push5(8'h88, 8'h04, 8'hA1, 8'hB2, 8'h9F);
        push5(8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h04);
        sak_bytes.push_back(8'h04);
        sak_bytes.push_back(8'h08);
        fire_irq();
        wait_end(2000);
        expect_success("card7", 80'hF6E5D4C3B2A104, 4'd7, 8'h08, 15, 1);
        check("card7_sel_count", sel_log.size(), 2);
        check("card7_sel_l1", (sel_log.size() > 0) ? sel_log[0] : 8'hXX, 8'h93);
        check("card7_sel_l2", (sel_log.size() > 1) ? sel_log[1] : 8'hXX, 8'h95);
        check("card7_select_l1", (select_log.size() > 0) ? select_log[0] : 8'hXX, 8'h50);
        check("card7_select_l2", (select_log.size() > 1) ? select_log[1] : 8'hXX, 8'h51);
        atqa_v = 8'h04;

        // Bad BCC on the first attempt, good on the retry.
        snapshot();
        push5(8'h78, 8'h56, 8'h34, 8'h12, 8'h09);
        push5(8'h78, 8'h56, 8'h34, 8'h12, 8'h08);
        sak_bytes.push_back(8'h08);
        fire_irq();
        wait_end(3000);
        expect_success("bcc_retry", 80'h12345678, 4'd4, 8'h08, 15, 2);

        // Bad BCC on all MAX_RETRIES+1 attempts.
        snapshot();
        for (int k = 0; k < 3; k++) push5(8'h78, 8'h56, 8'h34, 8'h12, 8'h09);
        fire_irq();
        wait_end(3000);
        expect_failure("bcc_fail", 8'h02, 21, 3);

        // ATQA 8'hFF is terminal without retry.
        snapshot();
        atqa_v = 8'hFF;
        fire_irq();
        wait_end(1000);
        expect_failure("atqa_ff", 8'h01, 1, 1);
        atqa_v = 8'h04;

        // Cascade tag seen but SAK says UID complete.
        snapshot();
        push5(8'h88, 8'h04, 8'hA1, 8'hB2, 8'h9F);
        sak_bytes.push_back(8'h08);
        fire_irq();
        wait_end(2000);
        expect_failure("tag_sak", 8'h03, 8, 1);

        // SELECT never completes: timeout on each attempt.
        snapshot();
        hold_select = 1'b1;
        for (int k = 0; k < 3; k++) push5(8'h78, 8'h56, 8'h34, 8'h12, 8'h08);
        fire_irq();
        wait_end(6000);
        expect_failure("timeout", 8'h05, 24, 3);
        // Timeout fires 1024 cycles after accept, then 3 cycles to retry and reissue REQA.
        check("timeout_gap",
              (select_cyc_log.size() > 0 && reqa_cyc_log.size() > 1) ?
                  reqa_cyc_log[1] - select_cyc_log[0] : -1,
              1027);
        hold_select = 1'b0;

        // Reset in the middle of READ_UID, then a fresh sequence.
        snapshot();
        push5(8'h78, 8'h56, 8'h34, 8'h12, 8'h08);
        sak_bytes.push_back(8'h08);
        fire_irq();
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (n_fifo - b_fifo >= 2) break;
        end
        check("mid_reached_read", (n_fifo - b_fifo >= 2), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_valid", nfc_cmd_valid, 0);
        check("mid_rst_detected", card_detected, 0);
        check("mid_rst_uid", card_uid, 0);
        check("mid_rst_len", uid_len, 0);
        check("mid_rst_sak", card_sak, 0);
        check("mid_rst_code", error_code, 8'h00);
        @(posedge clk); #1 rst = 1'b0;
        fifo_bytes.delete();
        sak_bytes.delete();
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst_stays_idle", card_detected, 0);
        snapshot();
        push5(8'h78, 8'h56, 8'h34, 8'h12, 8'h08);
        sak_bytes.push_back(8'h08);
        fire_irq();
        wait_end(2000);
        expect_success("after_rst", 80'h12345678, 4'd4, 8'h08, 8, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nfc_cascade_detector.md
# nfc_cascade_detector

Parametrised ISO14443A card detector supporting single-, double- and triple-size UIDs (4/7/10 bytes) via cascade levels, with per-transaction timeout and automatic retry. Sits between the NFC front-end command bus (MFRC522 command/response interface) and the authentication controller. On a rising `nfc_irq` it runs REQA → ANTICOLL/SELECT per cascade level, assembles the full UID, and triggers authentication.

## Interface
- `MAX_CASCADE`, 3: supported cascade levels, 1..3; `UID_W = 8*(3*MAX_CASCADE+1)`.
- `MAX_RETRIES`, 2: full-sequence retries after recoverable errors.
- `TIMEOUT_CYCLES`, 1024: max cycles from command accept to `nfc_cmd_done`.
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `nfc_irq`  in  1  card-present interrupt, level; rising edge starts detection
- `nfc_cmd_valid`  out  1  command request
- `nfc_cmd_ready`  in  1  front-end accepts command
- `nfc_cmd_write`  out  1  1 = write, 0 = read
- `nfc_cmd_addr`  out  6  register address
- `nfc_cmd_wdata`  out  8  write data
- `nfc_cmd_rdata`  in  8  response byte, valid with `nfc_cmd_done`
- `nfc_cmd_done`  in  1  one-cycle completion pulse
- `card_detected`  out  1  high while a sequence is in progress
- `card_uid`  out  UID_W  UID, first received byte in [7:0]; unused bytes zero
- `uid_len`  out  4  4, 7 or 10; 0 when no valid UID
- `card_sak`  out  8  final SAK
- `card_ready`  out  1  one-cycle pulse, UID valid
- `start_auth`  out  1  one-cycle pulse, coincident with `card_ready`
- `detection_error`  out  1  one-cycle pulse on terminal failure
- `error_code`  out  8  last error code, held

## Operation
- Transactions: write to `CMD_REG` (6'h01), `SEL_REG` (6'h02); reads from `FIFO_REG` (6'h09).
- States: IDLE, REQA, ANTICOLL, READ_UID, CHK_BCC, SELECT, CHK_SAK, DONE, ERROR.
- IDLE: on `nfc_irq` rising edge (registered previous value) → clear `card_uid`, `uid_len`, `card_sak`, retry count, level=0 → REQA. IRQ edges outside IDLE ignored.
- REQA: write `CMD_REG`=8'h26; response is ATQA. 8'h00 or 8'hFF → ERROR code 8'h01 (no retry).
- ANTICOLL: write `SEL_REG` with SEL code 8'h93/8'h95/8'h97 for level 0/1/2; response ignored.
- READ_UID: 5 reads of `FIFO_REG` → bytes b0..b3, BCC.
- CHK_BCC: b0^b1^b2^b3 ≠ BCC → code 8'h02 (retryable). b0 = 8'h88 (cascade tag): append b1..b3; else append b0..b3.
- SELECT: write `CMD_REG`=8'h50 | level; response = SAK.
- CHK_SAK: SAK bit2 set iff cascade tag seen, else code 8'h03. Bit2 set and level+1 == MAX_CASCADE → code 8'h04. Bit2 set → level+1, ANTICOLL. Bit2 clear → DONE.
- DONE: set `uid_len`, `card_sak`; pulse `card_ready`, `start_auth`; → IDLE.
- Timeout on any transaction → code 8'h05 (retryable). Retryable with retry count < MAX_RETRIES: increment, clear UID, level=0, → REQA. Otherwise ERROR: pulse `detection_error`, → IDLE.

## Timing
- Reset: all outputs 0, `error_code` 8'h00, state IDLE.
- Handshake: `valid` asserted with stable addr/write/wdata until cycle where `valid && ready`; deasserted next cycle. Wait for `done`; `rdata` captured on the `done` cycle; next command earliest the following cycle.
- Timeout counter starts at accept cycle; fires when count reaches TIMEOUT_CYCLES with no `done`. A `done` arriving in the same cycle as the timeout fire wins.
- `card_detected` high from the cycle after the IRQ edge until the DONE/ERROR cycle inclusive.
- `card_uid`/`uid_len`/`card_sak` hold until the next sequence starts. `error_code` holds until the next error.
- Reset mid-sequence: immediate return to IDLE; `nfc_cmd_valid` low the next cycle.

## Structure
- Package `nfc_pkg`: state enum, register addresses, SEL codes, cascade tag 8'h88, error codes.
- Sub-module `nfc_cmd_xact`: single-transaction engine (valid/ready issue, done wait, timeout counter, rdata capture, `xact_ok`/`xact_timeout` pulses).

## Test plan
- 4-byte card: ATQA 8'h04; FIFO 78 56 34 12 08; SAK 8'h08 → `card_uid[31:0]`=32'h12345678, `uid_len`=4, `card_ready` and `start_auth` pulse once.
- 7-byte card: L1 FIFO 88 04 A1 B2 9F, SAK 8'h04; L2 FIFO C3 D4 E5 F6 04, SAK 8'h08 → `card_uid[55:0]`=56'hF6E5D4C3B2A104, `uid_len`=7.
- Bad BCC (08→09) on first attempt, good on retry → one retry, then success. BCC bad on every attempt → `detection_error`, `error_code`=8'h02 after MAX_RETRIES+1 attempts.
- Mock withholds `done` on SELECT → timeout after TIMEOUT_CYCLES, retries, final `error_code`=8'h05.
- ATQA 8'hFF → immediate `error_code`=8'h01, no retry. Cascade tag with SAK 8'h08 → 8'h03.
- Second IRQ during sequence ignored; `rst` asserted mid-READ_UID → IDLE, all outputs zero, a fresh IRQ completes normally.
